// File: rtl/axi4_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_arbiter
// Two-requester round-robin arbiter in front of a single AXI4 master port.
// Exactly one burst (read or write) is outstanding at any time.
//
// Ports
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]     per-requester command handshake
//   req_write [1:0]               1 = write burst, 0 = read burst
//   req_addr/req_len/req_size     packed per-requester address, LEN, SIZE
//   wd_valid/wd_ready [1:0]       per-requester write-data handshake
//   wd_data                       packed per-requester write data
//   rd_valid [1:0], rd_data, rd_last   read beat routed to the granted requester
//   done [1:0], resp [1:0]        one-cycle completion pulse and its response
//   AW/W/B/AR/R                   AXI4 master channels
// ---------------------------------------------------------------------------
module axi4_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  // requester command side
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]             req_len,
  input  logic [5:0]              req_size,
  // requester write data
  input  logic [1:0]              wd_valid,
  output logic [1:0]              wd_ready,
  input  logic [2*DATA_WIDTH-1:0] wd_data,
  // requester read data / completion
  output logic [1:0]              rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic [1:0]              done,
  output logic [1:0]              resp,
  // AXI4 AW
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  // AXI4 W
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic                    WVALID,
  output logic                    WLAST,
  input  logic                    WREADY,
  // AXI4 B
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  // AXI4 AR
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  // AXI4 R
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  input  logic                    RLAST,
  output logic                    RREADY
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;

  // unpacked views of the packed per-requester buses
  logic [ADDR_WIDTH-1:0] addr_arr [2];
  logic [7:0]            len_arr  [2];
  logic [2:0]            size_arr [2];
  logic [DATA_WIDTH-1:0] wdata_arr[2];

  logic [2:0]            state_reg;
  logic                  grant_reg;   // requester owning the current burst
  logic                  prio_reg;    // requester that wins the next tie
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]            len_reg;
  logic [2:0]            size_reg;
  logic [7:0]            cnt_reg;     // remaining W beats after the current one
  logic [1:0]            racc_reg;    // sticky OR of RRESP over the read burst

  logic any_req;
  logic pick;
  logic in_idle, in_w, in_b, in_r;
  logic b_done, r_done;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_arr[gi]   = req_len[gi*8 +: 8];
      assign size_arr[gi]  = req_size[gi*3 +: 3];
      assign wdata_arr[gi] = wd_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign in_idle = (state_reg == S_IDLE);
  assign in_w    = (state_reg == S_W);
  assign in_b    = (state_reg == S_B);
  assign in_r    = (state_reg == S_R);

  // Round robin: on a tie the priority pointer decides, otherwise the lone
  // requester wins.
  assign any_req = |req_valid;
  assign pick    = (&req_valid) ? prio_reg : req_valid[1];

  assign b_done = in_b & BVALID;
  assign r_done = in_r & RVALID & RLAST;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_route
      assign req_ready[gi] = in_idle & any_req & (pick == 1'(gi));
      assign wd_ready[gi]  = in_w & WREADY & (grant_reg == 1'(gi));
      assign rd_valid[gi]  = in_r & RVALID & (grant_reg == 1'(gi));
      assign done[gi]      = (b_done | r_done) & (grant_reg == 1'(gi));
    end
  endgenerate

  // AXI master outputs
  assign AWADDR  = addr_reg;
  assign AWLEN   = len_reg;
  assign AWSIZE  = size_reg;
  assign AWVALID = (state_reg == S_AW);
  assign ARADDR  = addr_reg;
  assign ARLEN   = len_reg;
  assign ARSIZE  = size_reg;
  assign ARVALID = (state_reg == S_AR);

  assign WDATA  = wdata_arr[grant_reg];
  assign WVALID = in_w & wd_valid[grant_reg];
  assign WLAST  = in_w & (cnt_reg == 8'd0);
  assign BREADY = in_b;
  assign RREADY = in_r;

  assign rd_data = RDATA;
  assign rd_last = in_r & RVALID & RLAST;

  // The final RRESP is folded in combinationally so the done pulse carries
  // the response of every beat including the last one.
  always_comb begin
    resp = 2'b00;
    if (b_done)      resp = BRESP;
    else if (r_done) resp = racc_reg | RRESP;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg <= S_IDLE;
      grant_reg <= 1'b0;
      prio_reg  <= 1'b0;
      addr_reg  <= '0;
      len_reg   <= '0;
      size_reg  <= '0;
      cnt_reg   <= '0;
      racc_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (any_req) begin
            grant_reg <= pick;
            addr_reg  <= addr_arr[pick];
            len_reg   <= len_arr[pick];
            size_reg  <= size_arr[pick];
            cnt_reg   <= len_arr[pick];
            racc_reg  <= 2'b00;
            state_reg <= req_write[pick] ? S_AW : S_AR;
          end
        end
        S_AW: begin
          if (AWREADY) state_reg <= S_W;
        end
        S_W: begin
          // a stalled requester (wd_valid low) simply leaves WVALID low
          if (WVALID && WREADY) begin
            if (cnt_reg == 8'd0) state_reg <= S_B;
            else                 cnt_reg   <= cnt_reg - 8'd1;
          end
        end
        S_B: begin
          if (BVALID) begin
            state_reg <= S_IDLE;
            prio_reg  <= ~grant_reg;
          end
        end
        S_AR: begin
          if (ARREADY) state_reg <= S_R;
        end
        S_R: begin
          if (RVALID) begin
            racc_reg <= racc_reg | RRESP;
            if (RLAST) begin
              state_reg <= S_IDLE;
              prio_reg  <= ~grant_reg;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4_arbiter.md
AXI4_ARBITER -- requirements
Module: axi4_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16, byte address width in bits.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESETn  in  1  asynchronous, active-low reset.
REQ-005 req_valid / req_ready  in / out  2 / 2  per-requester command handshake; bit i is requester i.
REQ-006 req_write  in  2  per requester: 1 = write burst, 0 = read burst.
REQ-007 req_addr / req_len / req_size  in  2*ADDR_WIDTH / 16 / 6  packed per-requester AWADDR/ARADDR, LEN, SIZE; slice i belongs to requester i.
REQ-008 wd_valid / wd_ready  in / out  2 / 2  per-requester write-data handshake; wd_data  in  2*DATA_WIDTH  packed.
REQ-009 rd_valid  out  2; rd_data  out  DATA_WIDTH; rd_last  out  1  read beat to granted requester.
REQ-010 done  out  2  one-cycle completion pulse; resp  out  2  completion response, valid with done.
REQ-011 AXI4 master port AW (AWADDR, AWLEN, AWSIZE, AWVALID out; AWREADY in), W (WDATA, WVALID, WLAST out; WREADY in), B (BRESP, BVALID in; BREADY out), AR (ARADDR, ARLEN, ARSIZE, ARVALID out; ARREADY in), R (RDATA, RRESP, RVALID, RLAST in; RREADY out), standard AXI4 widths.

Function
REQ-012 FSM states: IDLE, AW, W, B, AR, R; one transaction outstanding at a time.
REQ-013 IDLE: if any req_valid, grant one requester g, pulse req_ready[g] for one cycle, latch addr/len/size/write, go to AW (write) or AR (read).
REQ-014 Arbitration round-robin: both requesting -> grant the requester not granted last; pointer updates at completion; after reset requester 0 wins ties.
REQ-015 AW/AR: AWVALID/ARVALID high with latched fields, held stable until AWREADY/ARREADY sampled high, then to W/R.
REQ-016 W: WVALID = wd_valid[g], WDATA = wd_data slice g, wd_ready[g] = WREADY (combinational); other wd_ready bits 0.
REQ-017 W beat counter loads req_len; decrements per WVALID&WREADY beat; WLAST = (counter == 0); last beat -> B.
REQ-018 B: BREADY = 1; on BVALID: done[g] = 1, resp = BRESP for one cycle, return to IDLE.
REQ-019 R: RREADY = 1; rd_valid[g] = RVALID, rd_data = RDATA, rd_last = RLAST; other rd_valid bits 0.
REQ-020 R: resp sticky-ORs RRESP across beats (any SLVERR -> 2'b10); RVALID&RLAST -> done[g] pulse with accumulated resp, to IDLE.
REQ-021 req_len = 0 is a single beat: WLAST asserted on first W beat.
REQ-022 Requester stalls (wd_valid low) hold the W state indefinitely; no beat counted.
REQ-023 req_valid of the non-granted requester is ignored until IDLE; request deassertion after grant has no effect.
REQ-024 done never asserted for both requesters in one cycle; new grant no earlier than cycle after done.

Reset
REQ-025 ARESETn low: state IDLE, grant pointer to requester 0, counters 0.
REQ-026 Outputs at reset: AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, req_ready, wd_ready, rd_valid, rd_last, done = 0; resp, address/len/size outputs = 0.
REQ-027 Reset mid-burst aborts the transaction immediately; no done pulse issued for it.

Verification
REQ-028 Req0 write addr 0x0010, len 3, size 2, AWREADY=1, WREADY=1 -> 4 W beats, WLAST on 4th only, BRESP 00 -> done[0] with resp 00.
REQ-029 Both requesters issue reads simultaneously after reset -> requester 0 granted first, requester 1 next; repeated -> alternates 0,1,0,1.
REQ-030 Read len 0 with RRESP 10 -> ARLEN 0, one rd_valid[g] beat with rd_last 1, done[g] with resp 10.
REQ-031 Write len 7, wd_valid toggled every other cycle and WREADY randomized -> exactly 8 beats, data in order, WLAST only on beat 8.
REQ-032 ARESETn asserted during R beat 2 of a 4-beat read -> all outputs to reset values asynchronously, no done; next request served normally.
